// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - registered EX-stage operand forwarding select decode
module forwarding_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_EXRs1,
  input  logic [REG_ADDR_W-1:0] ID_EXRs2,
  input  logic [REG_ADDR_W-1:0] EX_MEMRegRd,
  input  logic                  EX_MEMRegWrite,
  input  logic                  MEM_WBRegWrite,
  input  logic [REG_ADDR_W-1:0] MEM_WBRegRd,
  output logic [1:0]            Fwd_A,
  output logic [1:0]            Fwd_B
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EX_MEM  = 2'b10;
  localparam logic [1:0] SEL_MEM_WB  = 2'b01;

  // x0 is hardwired to zero, so a zero destination is never a real producer.
  logic ex_mem_live;
  logic mem_wb_live;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  assign ex_mem_live = EX_MEMRegWrite && (EX_MEMRegRd != '0);
  assign mem_wb_live = MEM_WBRegWrite && (MEM_WBRegRd != '0);

  // Operand A decode; EX/MEM checked first because it holds the youngest producer.
  always_comb begin
    fwd_a_next = SEL_REGFILE;
    if (ex_mem_live && (EX_MEMRegRd == ID_EXRs1)) begin
      fwd_a_next = SEL_EX_MEM;
    end else if (mem_wb_live && (MEM_WBRegRd == ID_EXRs1)) begin
      fwd_a_next = SEL_MEM_WB;
    end
  end

  // Operand B decode, independent of operand A.
  always_comb begin
    fwd_b_next = SEL_REGFILE;
    if (ex_mem_live && (EX_MEMRegRd == ID_EXRs2)) begin
      fwd_b_next = SEL_EX_MEM;
    end else if (mem_wb_live && (MEM_WBRegRd == ID_EXRs2)) begin
      fwd_b_next = SEL_MEM_WB;
    end
  end

  // Register the selects so they line up with the EX operand muxes next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Fwd_A <= SEL_REGFILE;
      Fwd_B <= SEL_REGFILE;
    end else begin
      Fwd_A <= fwd_a_next;
      Fwd_B <= fwd_b_next;
    end
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// tb/tb_forwarding_unit.sv - scoreboard bench for forwarding_unit
module tb_forwarding_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, ex_rd, wb_rd;
  logic       ex_wr, wb_wr;
  logic [1:0] Fwd_A, Fwd_B;

  int vectors;
  int miscompares;
  logic [3:0] exp_q[$];

  forwarding_unit #(.REG_ADDR_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ID_EXRs1(rs1),
    .ID_EXRs2(rs2),
    .EX_MEMRegRd(ex_rd),
    .EX_MEMRegWrite(ex_wr),
    .MEM_WBRegWrite(wb_wr),
    .MEM_WBRegRd(wb_rd),
    .Fwd_A(Fwd_A),
    .Fwd_B(Fwd_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: checks sources in order, young producer first.
  function automatic logic [1:0] ref_sel(input logic [4:0] src, input logic [4:0] erd,
                                         input logic ewr, input logic [4:0] wrd, input logic wwr);
    logic [1:0] r;
    r = 2'b00;
    if (wwr && wrd == src && wrd != 5'd0) r = 2'b01;
    if (ewr && erd == src && erd != 5'd0) r = 2'b10;
    return r;
  endfunction

  // Drive at the falling edge and queue the expected selects for the next rising edge.
  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] erd,
                       input logic ewr, input logic [4:0] wrd, input logic wwr,
                       input logic [1:0] ea, input logic [1:0] eb);
    @(negedge clk);
    rs1 = a1; rs2 = a2; ex_rd = erd; ex_wr = ewr; wb_rd = wrd; wb_wr = wwr;
    exp_q.push_back({ea, eb});
  endtask

  task automatic test_reset;
    logic [3:0] e;
    rst_n = 1'b0;
    rs1 = 5'd1; rs2 = 5'd1; ex_rd = 5'd1; ex_wr = 1'b1; wb_rd = 5'd0; wb_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (Fwd_A !== 2'b00 || Fwd_B !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: A=%b B=%b want 00 00", i, Fwd_A, Fwd_B);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({2'b10, 2'b10});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    vectors++;
    if (Fwd_A !== e[3:2] || Fwd_B !== e[1:0]) begin
      miscompares++;
      $display("FAIL reset_release: A=%b B=%b want %b %b", Fwd_A, Fwd_B, e[3:2], e[1:0]);
    end
  endtask

  task automatic test_table;
    // rs1 rs2 exrd exwr wbrd wbwr expA expB
    logic [4:0] t_rs1[11]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0] t_rs2[11]  = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};
    logic [4:0] t_erd[11]  = '{3, 1, 2, 1, 1, 2, 2, 1, 2, 4, 0};
    logic       t_ewr[11]  = '{1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1};
    logic [4:0] t_wrd[11]  = '{4, 4, 4, 1, 1, 2, 2, 1, 2, 2, 0};
    logic       t_wwr[11]  = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [1:0] t_ea[11]   = '{0, 2, 0, 2, 1, 0, 0, 0, 0, 0, 0};
    logic [1:0] t_eb[11]   = '{0, 0, 2, 0, 0, 2, 1, 0, 0, 1, 0};
    logic [3:0] e;
    for (int i = 0; i < 11; i++) begin
      drive(t_rs1[i], t_rs2[i], t_erd[i], t_ewr[i], t_wrd[i], t_wwr[i], t_ea[i], t_eb[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      vectors++;
      if (Fwd_A !== e[3:2] || Fwd_B !== e[1:0]) begin
        miscompares++;
        $display("FAIL table[%0d]: A=%b B=%b want %b %b", i, Fwd_A, Fwd_B, e[3:2], e[1:0]);
      end
    end
  endtask

  task automatic test_latency;
    logic [3:0] e;
    drive(5'd7, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 2'b10, 2'b10);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    vectors++;
    if (Fwd_A !== e[3:2] || Fwd_B !== e[1:0]) begin
      miscompares++;
      $display("FAIL latency_load: A=%b B=%b want %b %b", Fwd_A, Fwd_B, e[3:2], e[1:0]);
    end
    // Mid-cycle change must not reach the outputs before the next edge.
    #1;
    ex_wr = 1'b0; wb_rd = 5'd7; wb_wr = 1'b1;
    exp_q.push_back({2'b01, 2'b01});
    #2;
    vectors++;
    if (Fwd_A !== 2'b10 || Fwd_B !== 2'b10) begin
      miscompares++;
      $display("FAIL latency_hold: A=%b B=%b want 10 10", Fwd_A, Fwd_B);
    end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    vectors++;
    if (Fwd_A !== e[3:2] || Fwd_B !== e[1:0]) begin
      miscompares++;
      $display("FAIL latency_next: A=%b B=%b want %b %b", Fwd_A, Fwd_B, e[3:2], e[1:0]);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] e;
    drive(5'd3, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 2'b10, 2'b01);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    vectors++;
    if (Fwd_A !== e[3:2] || Fwd_B !== e[1:0]) begin
      miscompares++;
      $display("FAIL async_pre: A=%b B=%b want %b %b", Fwd_A, Fwd_B, e[3:2], e[1:0]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (Fwd_A !== 2'b00 || Fwd_B !== 2'b00) begin
      miscompares++;
      $display("FAIL async_assert: A=%b B=%b want 00 00", Fwd_A, Fwd_B);
    end
    @(posedge clk); #1;
    vectors++;
    if (Fwd_A !== 2'b00 || Fwd_B !== 2'b00) begin
      miscompares++;
      $display("FAIL async_hold: A=%b B=%b want 00 00", Fwd_A, Fwd_B);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    logic [4:0] a1, a2, erd, wrd;
    logic ewr, wwr;
    for (int i = 0; i < 40; i++) begin
      a1 = 5'($urandom_range(0, 3)); a2 = 5'($urandom_range(0, 3));
      erd = 5'($urandom_range(0, 3)); wrd = 5'($urandom_range(0, 3));
      ewr = 1'($urandom_range(0, 1)); wwr = 1'($urandom_range(0, 1));
      drive(a1, a2, erd, ewr, wrd, wwr, ref_sel(a1, erd, ewr, wrd, wwr), ref_sel(a2, erd, ewr, wrd, wwr));
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b2b_queue[%0d]: scoreboard empty, want 1 entry", i);
      end else begin
        e = exp_q.pop_front();
        vectors++;
        if (Fwd_A !== e[3:2] || Fwd_B !== e[1:0]) begin
          miscompares++;
          $display("FAIL b2b[%0d]: A=%b B=%b want %b %b", i, Fwd_A, Fwd_B, e[3:2], e[1:0]);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_table();
    test_latency();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
Data-hazard forwarding control for the 5-stage RISC-V RV32 pipeline. It compares the EX-stage source registers (rs1, rs2) against the destination registers of the EX/MEM and MEM/WB pipeline registers. It produces the 2-bit mux selects that drive the ALU operand A and operand B forwarding muxes. The selects are registered so that they align with the EX-stage operand muxes one cycle later.

Parameters:
REG_ADDR_W, 5, width of register-index fields (32 architectural registers).

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
ID_EXRs1  input  REG_ADDR_W  rs1 index held in the ID/EX register.
ID_EXRs2  input  REG_ADDR_W  rs2 index held in the ID/EX register.
EX_MEMRegRd  input  REG_ADDR_W  rd index held in the EX/MEM register.
EX_MEMRegWrite  input  1  register-write enable of the instruction in EX/MEM.
MEM_WBRegWrite  input  1  register-write enable of the instruction in MEM/WB.
MEM_WBRegRd  input  REG_ADDR_W  rd index held in the MEM/WB register.
Fwd_A  output  2  operand A mux select, registered.
Fwd_B  output  2  operand B mux select, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n). Port order is as listed above.
- Select encoding, identical for A and B:
  - 2'b00: use the register-file value from ID/EX.
  - 2'b10: forward the ALU result from EX/MEM.
  - 2'b01: forward the writeback value from MEM/WB.
  - 2'b11: never produced.
- Next-value decode for Fwd_A is combinational, evaluated in priority order:
  - if EX_MEMRegWrite=1 and EX_MEMRegRd!=0 and EX_MEMRegRd==ID_EXRs1, the result is 10;
  - else if MEM_WBRegWrite=1 and MEM_WBRegRd!=0 and MEM_WBRegRd==ID_EXRs1, the result is 01;
  - else the result is 00.
- Fwd_B uses the same decode with ID_EXRs2 in place of ID_EXRs1.
- Decodes for A and B are fully independent. Both may select the same source, or different sources, in the same cycle.
- EX/MEM has priority over MEM/WB when both match, because it holds the most recent producer.
- Register x0 is never forwarded. A destination index of 0 never matches, even when write enable is set and the source index is 0.
- A write enable of 0 suppresses a match from that stage regardless of index equality.
- Latency: the decoded selects are captured into Fwd_A/Fwd_B on each rising clk edge. The outputs reflect inputs sampled at the previous edge, a fixed latency of 1 cycle. There is no enable and no stall input; the registers update every cycle.
- Reset:
  - rst_n low immediately forces Fwd_A=00 and Fwd_B=00, asynchronously, regardless of clk.
  - Both outputs hold 00 while rst_n is low.
  - On the first rising edge after rst_n deasserts, the outputs load the current decode.
  - Reset asserted mid-operation discards any pending decode.
- Inputs that are X or Z are outside scope; the outputs follow Verilog semantics for them.
- No other internal state.

Test Plan:
- Reset: hold rst_n=0 with inputs rs1=1, rs2=1, EX rd=1, EXWr=1 and toggle clk. Required: Fwd_A=Fwd_B=00 throughout. Release reset; after the next edge, Fwd_A=10 and Fwd_B=10.
- No hazard: rs1=1, rs2=2, EX rd=3, WB rd=4, EXWr=1, WBWr=1. After the edge: Fwd_A=00, Fwd_B=00.
- EX/MEM forwarding, per operand:
  - rs1=1, rs2=2, EX rd=1, WB rd=4, EXWr=1, WBWr=0 gives Fwd_A=10, Fwd_B=00.
  - With EX rd=2 instead: Fwd_A=00, Fwd_B=10.
- Priority and MEM/WB forwarding:
  - rs1=1, rs2=2, EX rd=WB rd=1, both write enables 1: Fwd_A=10 (EX wins).
  - Same with EXWr=0: Fwd_A=01.
  - Repeat with rd=2 to get Fwd_B=10, then Fwd_B=01.
- Write-enable gating: rs1=1, rs2=2, EX rd=WB rd=1 (then 2), both write enables 0. Required: Fwd_A=Fwd_B=00.
- x0 guard: all indices 0, EXWr=1, WBWr=1. Required: Fwd_A=Fwd_B=00. Also check the 1-cycle latency by changing inputs mid-cycle; outputs must change only at the next rising edge.
